// File: rtl/avg_seq_ctrl.sv
// rtl/avg_seq_ctrl.sv - sequenced averaging datapath: halves packed element sums with vxrm rounding
// over a two-stage stallable pipeline.
module avg_seq_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int DW_B          = DATA_WIDTH >> 3,
  parameter int ENABLE_64_BIT = 1,
  parameter int VL_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [VL_W-1:0]       cmd_vl,
  input  logic [1:0]            cmd_sew,
  input  logic [1:0]            cmd_vxrm,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DW_B-1:0]       out_be,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int DWB_LG = $clog2(DW_B);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state_q, state_d;

  logic [1:0]            sew_q, vxrm_q;
  logic [VL_W-1:0]       total_q, issued_q, part_q;
  logic                  s1_valid, s1_last, s2_valid, s2_last;
  logic [DATA_WIDTH-1:0] s1_shift, s1_vd, s1_vd1, s2_data;
  logic [DW_B-1:0]       s1_be, s2_be;
  logic                  done_q, cmd_err_q;

  logic                  stall, cmd_fire, cmd_illegal, cmd_start;
  logic                  in_fire, last_issue, final_fire;
  logic [VL_W:0]         cmd_epb;
  logic [4:0]            cmd_lg;
  logic [VL_W-1:0]       cmd_total, cmd_part;
  logic [DATA_WIDTH-1:0] lsb_mask, msb_mask, byte_mask, rnd, s2_next;
  logic [DW_B-1:0]       beat_be;

  assign out_valid   = s2_valid;
  assign out_data    = s2_data;
  assign out_be      = s2_be;
  assign done        = done_q;
  assign cmd_err     = cmd_err_q;

  assign stall       = s2_valid & ~out_ready;
  assign cmd_ready   = (state_q == IDLE);
  assign in_ready    = (state_q == RUN) && (issued_q < total_q) && !stall;
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign cmd_illegal = (cmd_sew == 2'd3) && (ENABLE_64_BIT == 0);
  assign cmd_start   = cmd_fire && !cmd_illegal && (cmd_vl != '0);
  assign in_fire     = in_valid & in_ready;
  assign last_issue  = (issued_q == total_q - 1'b1);
  assign final_fire  = s2_valid & out_ready & s2_last;

  // Beat count and final-beat byte count; elements per beat is a power of two.
  always_comb begin
    cmd_epb   = (VL_W+1)'(DW_B) >> cmd_sew;
    cmd_lg    = 5'(DWB_LG) - {3'b000, cmd_sew};
    cmd_total = VL_W'(({1'b0, cmd_vl} + cmd_epb - 1'b1) >> cmd_lg);
    cmd_part  = VL_W'((cmd_vl & (cmd_epb[VL_W-1:0] - 1'b1)) << cmd_sew);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_start) state_d = RUN;
      RUN:     if (in_fire && last_issue) state_d = DRAIN;
      DRAIN:   if (final_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Element LSB/MSB masks let one full-width add round every element; the cleared MSB
  // after the shift guarantees the increment never carries into the next element.
  always_comb begin
    lsb_mask  = '0;
    msb_mask  = '0;
    byte_mask = '0;
    beat_be   = '0;
    rnd       = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      lsb_mask[i]  = ((i & ((8 << sew_q) - 1)) == 0);
      msb_mask[i]  = ((i & ((8 << sew_q) - 1)) == ((8 << sew_q) - 1));
      byte_mask[i] = s1_be[i/8];
    end
    for (int b = 0; b < DW_B; b++)
      beat_be[b] = !last_issue || (part_q == '0) || (VL_W'(b) < part_q);
    case (vxrm_q)
      2'd0:    rnd = s1_vd1;
      2'd1:    rnd = s1_vd1 & s1_vd;
      2'd2:    rnd = '0;
      default: rnd = s1_vd1 & ~s1_vd;
    endcase
    s2_next = (s1_shift + rnd) & byte_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sew_q     <= '0;
      vxrm_q    <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      part_q    <= '0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_shift  <= '0;
      s1_vd     <= '0;
      s1_vd1    <= '0;
      s1_be     <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_data   <= '0;
      s2_be     <= '0;
    end else begin
      done_q    <= (cmd_fire && !cmd_illegal && (cmd_vl == '0)) || final_fire;
      cmd_err_q <= cmd_fire && cmd_illegal;
      if (cmd_start) begin
        sew_q    <= cmd_sew;
        vxrm_q   <= cmd_vxrm;
        total_q  <= cmd_total;
        part_q   <= cmd_part;
        issued_q <= '0;
      end else if (in_fire) begin
        issued_q <= issued_q + 1'b1;
      end
      if (!stall) begin
        s1_valid <= in_fire;
        s1_last  <= in_fire & last_issue;
        s1_shift <= (in_data >> 1) & ~msb_mask;
        s1_vd1   <= in_data & lsb_mask;
        s1_vd    <= (in_data >> 1) & lsb_mask;
        s1_be    <= beat_be;
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        s2_data  <= s1_valid ? s2_next : '0;
        s2_be    <= s1_valid ? s1_be : '0;
      end
    end
  end

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// tb/tb_avg_seq_ctrl.sv - scoreboard bench for avg_seq_ctrl with an element-level reference model.
module tb_avg_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_vl = '0;
  logic [1:0]  cmd_sew = '0, cmd_vxrm = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_be;
  logic        done, cmd_err;

  logic        cmd_valid_n = 1'b0, cmd_ready_n;
  logic [15:0] cmd_vl_n = '0;
  logic [1:0]  cmd_sew_n = '0, cmd_vxrm_n = '0;
  logic        in_ready_n, out_valid_n, done_n, cmd_err_n;
  logic [63:0] out_data_n;
  logic [7:0]  out_be_n;

  always #5 clk = ~clk;

  avg_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_vxrm(cmd_vxrm),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .done(done), .cmd_err(cmd_err)
  );

  avg_seq_ctrl #(.ENABLE_64_BIT(0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_n), .cmd_ready(cmd_ready_n), .cmd_vl(cmd_vl_n),
    .cmd_sew(cmd_sew_n), .cmd_vxrm(cmd_vxrm_n),
    .in_valid(1'b0), .in_ready(in_ready_n), .in_data(64'd0),
    .out_valid(out_valid_n), .out_ready(1'b1), .out_data(out_data_n),
    .out_be(out_be_n), .done(done_n), .cmd_err(cmd_err_n)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, fails = 0;
  bit          done_due = 0, zdone = 0, prev_stall = 0;
  logic [63:0] hold_d = '0, last_out = '0;
  logic [7:0]  hold_be = '0, last_be = '0;
  int          rmode = 0;
  bit          gaps = 0;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  // Reference: element-by-element halving with the rounding rule written out directly.
  function automatic exp_t model_beat(logic [63:0] din, int b, int vl, int sew, int vxrm, int nb);
    exp_t e;
    int w = 8 << sew;
    int epb = 8 >> sew;
    logic [63:0] mask = ~64'd0 >> (64 - w);
    logic [63:0] s, r, res;
    e.data = '0;
    e.be = '0;
    e.last = (b == nb - 1);
    for (int k = 0; k < epb; k++) begin
      if (b * epb + k < vl) begin
        s = (din >> (k * w)) & mask;
        case (vxrm)
          0: r = {63'd0, s[0]};
          1: r = {63'd0, s[0] & s[1]};
          2: r = 64'd0;
          default: r = {63'd0, s[0] & ~s[1]};
        endcase
        res = (s >> 1) + r;
        e.data = e.data | (res << (k * w));
        e.be = e.be | 8'(((1 << (w / 8)) - 1) << (k * w / 8));
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
      done_due = 0;
    end else begin
      if (done_due) begin
        chk("done_pulse", done, 1);
        done_due = 0;
      end else if (done && !zdone) begin
        chk("unexpected_done", done, 0);
      end
      if (cmd_err) chk("unexpected_cmd_err", cmd_err, 0);
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, hold_d);
        chk("stall_hold_be", out_be, hold_be);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_be", out_be, e.be);
          last_out = out_data;
          last_be = out_be;
          if (e.last) done_due = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_d = out_data;
      hold_be = out_be;
    end
  end

  task automatic run_cmd(input int vl, input int sew, input int vxrm,
                         input logic [63:0] fixed, input bit use_fixed, input bit chk_lat);
    int epb = 8 >> sew;
    int nb = (vl + epb - 1) / epb;
    int t;
    logic [63:0] d[$];
    for (int b = 0; b < nb; b++) begin
      d.push_back(use_fixed ? fixed : {$urandom, $urandom});
      sb.push_back(model_beat(d[b], b, vl, sew, vxrm, nb));
    end
    if (vl == 0) zdone = 1;
    cmd_vl = 16'(vl);
    cmd_sew = 2'(sew);
    cmd_vxrm = 2'(vxrm);
    cmd_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 200) begin
        chk("timeout_cmd", cmd_ready, 1);
        cmd_valid = 1'b0;
        sb.delete();
        return;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (vl == 0) begin
      chk("zero_done", done, 1);
      chk("zero_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("zero_done_clear", done, 0);
      zdone = 0;
      return;
    end
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data = d[b];
      in_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        if (++t > 200) begin
          chk("timeout_beat", in_ready, 1);
          in_valid = 1'b0;
          sb.delete();
          return;
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (chk_lat && b == 0) begin
        chk("latency_t1", out_valid, 0);
        @(posedge clk); #1;
        chk("latency_t2", out_valid, 1);
      end
    end
    t = 0;
    while (!(sb.size() == 0 && !done_due && cmd_ready)) begin
      @(posedge clk); #1;
      if (++t > 400) begin
        chk("timeout_drain", 64'(sb.size()), 0);
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_be", out_be, 0);

    run_cmd(8, 0, 0, 64'h0303030303030303, 1, 1);
    chk("basic_data", last_out, 64'h0202020202020202);
    chk("basic_be", last_be, 8'hFF);

    for (int v = 0; v < 4; v++) begin
      run_cmd(8, 0, v, 64'h0101010101010101, 1, 0);
      chk("vxrm_byte", last_out, (v == 0 || v == 3) ? 64'h0101010101010101 : 64'h0);
    end

    run_cmd(5, 1, 0, 64'h0, 0, 0);
    chk("partial_be", last_be, 8'h03);
    chk("partial_upper_zero", last_out[63:16], 48'h0);

    rmode = 2;
    fork
      run_cmd(24, 0, 1, 64'h0, 0, 0);
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("stall_valid", out_valid, 1);
    chk("stall_in_ready_full", in_ready, 0);
    chk("stall_pending", 64'(sb.size()), 3);
    rmode = 0;
    wait fork;
    chk("stall_drained", 64'(sb.size()), 0);

    run_cmd(0, 0, 0, 64'h0, 0, 0);

    cmd_valid_n = 1'b1;
    cmd_sew_n = 2'd3;
    cmd_vl_n = 16'd4;
    chk("n_cmd_ready", cmd_ready_n, 1);
    @(posedge clk); #1;
    cmd_valid_n = 1'b0;
    chk("n_cmd_err", cmd_err_n, 1);
    chk("n_no_done", done_n, 0);
    chk("n_in_ready", in_ready_n, 0);
    @(posedge clk); #1;
    chk("n_cmd_err_clear", cmd_err_n, 0);
    chk("n_no_done_late", done_n, 0);
    chk("n_idle", cmd_ready_n, 1);

    cmd_vl = 16'd24;
    cmd_sew = 2'd0;
    cmd_vxrm = 2'd0;
    cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 200);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_data = {$urandom, $urandom};
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    chk("rst_test_beat_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_be", out_be, 0);
    run_cmd(12, 0, 2, 64'h0, 0, 0);

    rmode = 1;
    gaps = 1;
    repeat (40) begin
      int vl;
      vl = ($urandom_range(0, 5) == 0) ? $urandom_range(21, 64) : $urandom_range(0, 20);
      run_cmd(vl, $urandom_range(0, 3), $urandom_range(0, 3), 64'h0, 0, 0);
    end
    rmode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_sb_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
